// File: rtl/obstacle_pkg.sv
// Shared definitions for the obstacle_field game block: FSM state encoding,
// screen geometry, reload/start positions and the 12-bit colour constants
// ({red, green, blue}, 4 bits each).
package obstacle_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_CRASH = 2'd2
    } state_t;

    localparam int SCREEN_W   = 640;
    localparam int SCREEN_H   = 480;
    localparam int OBS_RELOAD = 640;   // obstacle parks just off the right edge
    localparam int PLAYER_Y0  = 232;   // player start row
    localparam int GAP_BASE   = 60;    // gap_y = GAP_BASE + lfsr value

    localparam logic [7:0] LFSR_SEED = 8'hA5;

    localparam logic [11:0] COL_BLACK  = 12'h000;
    localparam logic [11:0] COL_YELLOW = 12'hFF0;
    localparam logic [11:0] COL_RED    = 12'hF00;
    localparam logic [11:0] COL_GREEN  = 12'h0F0;
    localparam logic [11:0] COL_BG     = 12'h004;

endpackage

// File: rtl/obstacle_field_lfsr8.sv
// lfsr8: 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, seeded with
// LFSR_SEED on reset. Advances one step on every cycle with en=1.
// Ports: clk, rst_n (async active-low), en (step enable), q[7:0] (state).
module lfsr8
    import obstacle_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic [7:0] q
);

    logic [7:0] r_q;
    logic       w_fb;

    // Taps at stages 8,6,5,4 -> bits 7,5,4,3; shift left, feedback into bit 0.
    assign w_fb = r_q[7] ^ r_q[5] ^ r_q[4] ^ r_q[3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_q <= LFSR_SEED;
        else if (en)
            r_q <= {r_q[6:0], w_fb};
    end

    assign q = r_q;

endmodule

// File: rtl/obstacle_field.sv
// obstacle_field: side-scrolling obstacle game. A single obstacle column with
// a random vertical gap moves left once per frame; the player square moves up
// and down on buttons. Overlap outside the gap ends the game (CRASH).
// Ports:
//   clk, rst_n            pixel clock, async active-low reset
//   HQ, VQ, AR            current column/row and active-region flag
//   frame                 one-cycle per-frame pulse; all game updates happen here
//   start, btn_up/down    synchronised buttons, sampled only on frame
//   red, green, blue      registered pixel colour (one cycle after HQ/VQ/AR)
//   score                 obstacles passed, saturating at 255
//   crash                 high while in CRASH
module obstacle_field
    import obstacle_pkg::*;
#(
    parameter int OBS_SPEED   = 2,
    parameter int OBS_W       = 40,
    parameter int GAP_H       = 120,
    parameter int PLAYER_X    = 100,
    parameter int PLAYER_SZ   = 16,
    parameter int PLAYER_STEP = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] HQ,
    input  logic [9:0] VQ,
    input  logic       AR,
    input  logic       frame,
    input  logic       start,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic [7:0] score,
    output logic       crash
);

    localparam int PLAYER_Y_MAX = SCREEN_H - PLAYER_SZ;

    state_t      r_state;
    logic [9:0]  r_obs_x;
    logic [9:0]  r_player_y;
    logic [9:0]  r_gap_y;
    logic [7:0]  r_score;
    logic        r_crash;
    logic [11:0] r_rgb;

    logic [7:0]  w_lfsr;
    logic [9:0]  w_gap_next;
    logic [10:0] w_obs_r;      // obs_x + OBS_W, widened so it cannot wrap
    logic [10:0] w_gap_b;      // gap_y + GAP_H
    logic [10:0] w_player_b;   // player_y + PLAYER_SZ
    logic        w_hov;
    logic        w_vin;
    logic        w_collision;
    logic [9:0]  w_py_next;
    logic        w_player_px;
    logic        w_obs_px;
    logic [11:0] w_rgb;

    lfsr8 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (frame),
        .q     (w_lfsr)
    );

    // Gap row is taken from the LFSR value present on the frame, before it steps.
    assign w_gap_next = 10'(GAP_BASE) + {2'b00, w_lfsr};

    assign w_obs_r    = {1'b0, r_obs_x} + 11'(OBS_W);
    assign w_gap_b    = {1'b0, r_gap_y} + 11'(GAP_H);
    assign w_player_b = {1'b0, r_player_y} + 11'(PLAYER_SZ);

    assign w_hov = (11'(PLAYER_X) < w_obs_r) &&
                   ({1'b0, r_obs_x} < 11'(PLAYER_X + PLAYER_SZ));
    assign w_vin = (r_player_y >= r_gap_y) && (w_player_b <= w_gap_b);
    assign w_collision = w_hov && !w_vin;

    always_comb begin
        w_py_next = r_player_y;
        if (btn_up && !btn_down) begin
            if (r_player_y < 10'(PLAYER_STEP))
                w_py_next = '0;
            else
                w_py_next = r_player_y - 10'(PLAYER_STEP);
        end else if (btn_down && !btn_up) begin
            if ({1'b0, r_player_y} + 11'(PLAYER_STEP) > 11'(PLAYER_Y_MAX))
                w_py_next = 10'(PLAYER_Y_MAX);
            else
                w_py_next = r_player_y + 10'(PLAYER_STEP);
        end
    end

    // Game FSM; crash is registered alongside the state it reflects.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_obs_x    <= 10'(OBS_RELOAD);
            r_player_y <= 10'(PLAYER_Y0);
            r_gap_y    <= 10'(GAP_BASE);
            r_score    <= '0;
            r_crash    <= 1'b0;
        end else if (frame) begin
            case (r_state)
                ST_IDLE, ST_CRASH: begin
                    if (start) begin
                        r_state    <= ST_PLAY;
                        r_crash    <= 1'b0;
                        r_obs_x    <= 10'(OBS_RELOAD);
                        r_player_y <= 10'(PLAYER_Y0);
                        r_gap_y    <= w_gap_next;
                        r_score    <= '0;
                    end
                end
                ST_PLAY: begin
                    if (w_collision) begin
                        // Positions freeze on the crash frame so the hit stays visible.
                        r_state <= ST_CRASH;
                        r_crash <= 1'b1;
                    end else begin
                        r_player_y <= w_py_next;
                        if (r_obs_x <= 10'(OBS_SPEED)) begin
                            r_obs_x <= 10'(OBS_RELOAD);
                            r_gap_y <= w_gap_next;
                            if (r_score != 8'hFF)
                                r_score <= r_score + 8'd1;
                        end else begin
                            r_obs_x <= r_obs_x - 10'(OBS_SPEED);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Pixel classification against the current (frame-stable) registers.
    assign w_player_px = (HQ >= 10'(PLAYER_X)) &&
                         ({1'b0, HQ} < 11'(PLAYER_X + PLAYER_SZ)) &&
                         (VQ >= r_player_y) && ({1'b0, VQ} < w_player_b);
    assign w_obs_px = (r_state != ST_IDLE) &&
                      (HQ >= r_obs_x) && ({1'b0, HQ} < w_obs_r) &&
                      !((VQ >= r_gap_y) && ({1'b0, VQ} < w_gap_b));

    always_comb begin
        w_rgb = COL_BG;
        if (!AR)
            w_rgb = COL_BLACK;
        else if (w_player_px)
            w_rgb = (r_state == ST_CRASH) ? COL_RED : COL_YELLOW;
        else if (w_obs_px)
            w_rgb = COL_GREEN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_rgb <= COL_BLACK;
        else
            r_rgb <= w_rgb;
    end

    assign red   = r_rgb[11:8];
    assign green = r_rgb[7:4];
    assign blue  = r_rgb[3:0];
    assign score = r_score;
    assign crash = r_crash;

endmodule

// File: tb/tb_obstacle_field.sv
module tb_obstacle_field;
    import obstacle_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] HQ = '0, VQ = '0;
    logic       AR = 1'b0, frame = 1'b0, start = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
    logic [3:0] red, green, blue;
    logic [7:0] score;
    logic       crash;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state (0=idle, 1=play, 2=crash)
    int m_state, m_ox, m_py, m_gy, m_sc, m_lfsr;

    obstacle_field dut (
        .clk(clk), .rst_n(rst_n), .HQ(HQ), .VQ(VQ), .AR(AR), .frame(frame),
        .start(start), .btn_up(btn_up), .btn_down(btn_down),
        .red(red), .green(green), .blue(blue), .score(score), .crash(crash)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_state = 0; m_ox = 640; m_py = 232; m_gy = 60; m_sc = 0; m_lfsr = 8'hA5;
    endfunction

    function automatic void model_step(input bit s, input bit u, input bit d);
        bit coll;
        coll = (100 < m_ox + 40) && (m_ox < 116) &&
               !(m_py >= m_gy && m_py + 16 <= m_gy + 120);
        if (m_state != 1) begin
            if (s) begin
                m_state = 1; m_ox = 640; m_py = 232; m_sc = 0; m_gy = 60 + m_lfsr;
            end
        end else if (coll) begin
            m_state = 2;
        end else begin
            if (u && !d) m_py = (m_py < 4) ? 0 : m_py - 4;
            if (d && !u) m_py = (m_py + 4 > 464) ? 464 : m_py + 4;
            if (m_ox <= 2) begin
                m_ox = 640; m_gy = 60 + m_lfsr; m_sc = (m_sc == 255) ? 255 : m_sc + 1;
            end else m_ox = m_ox - 2;
        end
        m_lfsr = ((m_lfsr << 1) | (((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1)) & 255;
    endfunction

    function automatic logic [11:0] model_colour(input int hq, input int vq, input bit ar);
        if (!ar) return 12'h000;
        if (hq >= 100 && hq < 116 && vq >= m_py && vq < m_py + 16)
            return (m_state == 2) ? 12'hF00 : 12'hFF0;
        if (m_state != 0 && hq >= m_ox && hq < m_ox + 40 && !(vq >= m_gy && vq < m_gy + 120))
            return 12'h0F0;
        return 12'h004;
    endfunction

    task automatic do_frame(input bit s, input bit u, input bit d);
        @(negedge clk);
        frame = 1'b1; start = s; btn_up = u; btn_down = d;
        @(negedge clk);
        frame = 1'b0; start = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
        model_step(s, u, d);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({red, green, blue, score, crash} !== 21'd0) begin
            n_fail++; $display("FAIL reset_outputs: got rgb=%h score=%0d crash=%b want all 0", {red, green, blue}, score, crash);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            do_frame(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            n_checks++;
            if (dut.r_obs_x !== 10'd640 || dut.r_state !== ST_IDLE) begin
                n_fail++; $display("FAIL idle_hold: got obs_x=%0d state=%0d want 640/IDLE", dut.r_obs_x, dut.r_state);
            end
        end
        // Sweep a row band across the right of the screen: never green in IDLE.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); HQ = 10'(600 + i * 7); VQ = 10'(i * 3); AR = 1'b1;
            @(posedge clk); #1;
            n_checks++;
            if ({red, green, blue} !== 12'h004) begin
                n_fail++; $display("FAIL idle_no_obstacle: got %h want 004 at hq=%0d", {red, green, blue}, HQ);
            end
        end
    endtask

    task automatic test_movement();
        do_frame(1'b1, 1'b0, 1'b0);
        repeat (3) do_frame(1'b0, 1'b0, 1'b0);
        n_checks++;
        if (dut.r_obs_x !== 10'd634 || m_ox != 634) begin
            n_fail++; $display("FAIL move_obs_x: got %0d want 634", dut.r_obs_x);
        end
        n_checks++;
        if (dut.r_gap_y !== 10'(m_gy) || dut.r_player_y !== 10'd232) begin
            n_fail++; $display("FAIL move_regs: got gap=%0d py=%0d want gap=%0d py=232", dut.r_gap_y, dut.r_player_y, m_gy);
        end
        @(negedge clk); HQ = 10'd634; VQ = 10'd0; AR = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({red, green, blue} !== 12'h0F0) begin
            n_fail++; $display("FAIL move_green_pixel: got %h want 0f0", {red, green, blue});
        end
    endtask

    task automatic test_clamp();
        for (int i = 0; i < 60; i++) do_frame(1'b0, 1'b1, 1'b0);
        n_checks++;
        if (dut.r_player_y !== 10'd0 || m_py != 0) begin
            n_fail++; $display("FAIL clamp_top: got %0d want 0", dut.r_player_y);
        end
        for (int i = 0; i < 5; i++) do_frame(1'b0, 1'b1, 1'b1);
        n_checks++;
        if (dut.r_player_y !== 10'd0 || dut.r_obs_x !== 10'(m_ox)) begin
            n_fail++; $display("FAIL clamp_both: got py=%0d ox=%0d want 0/%0d", dut.r_player_y, dut.r_obs_x, m_ox);
        end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        force dut.r_obs_x = 10'd2;
        force dut.r_score = 8'd255;
        @(negedge clk);
        release dut.r_obs_x;
        release dut.r_score;
        m_ox = 2; m_sc = 255;
        do_frame(1'b0, 1'b0, 1'b0);
        n_checks++;
        if (dut.r_obs_x !== 10'd640 || score !== 8'd255) begin
            n_fail++; $display("FAIL wrap_sat: got ox=%0d score=%0d want 640/255", dut.r_obs_x, score);
        end
        n_checks++;
        if (dut.r_gap_y !== 10'(m_gy)) begin
            n_fail++; $display("FAIL wrap_gap: got %0d want %0d", dut.r_gap_y, m_gy);
        end
    endtask

    task automatic test_collision();
        bit u, d;
        for (int i = 0; i < 3000 && m_state != 2; i++) begin
            u = ($urandom_range(0, 3) != 0);
            d = ($urandom_range(0, 3) == 0);
            do_frame(1'b0, u, d);
            n_checks++;
            if (dut.r_obs_x !== 10'(m_ox) || dut.r_player_y !== 10'(m_py) ||
                dut.r_gap_y !== 10'(m_gy) || score !== 8'(m_sc) || crash !== (m_state == 2)) begin
                n_fail++;
                $display("FAIL play_step: got ox=%0d py=%0d gy=%0d sc=%0d cr=%b want %0d %0d %0d %0d %0d",
                         dut.r_obs_x, dut.r_player_y, dut.r_gap_y, score, crash, m_ox, m_py, m_gy, m_sc, m_state == 2);
            end
        end
        n_checks++;
        if (m_state != 2 || crash !== 1'b1) begin
            n_fail++; $display("FAIL crash_reached: got crash=%b want 1", crash);
        end
        @(negedge clk); HQ = 10'd100; VQ = 10'(m_py); AR = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({red, green, blue} !== 12'hF00) begin
            n_fail++; $display("FAIL crash_red_pixel: got %h want f00", {red, green, blue});
        end
        for (int i = 0; i < 5; i++) do_frame(1'b0, 1'b1, 1'b0);
        n_checks++;
        if (dut.r_obs_x !== 10'(m_ox) || dut.r_player_y !== 10'(m_py) || crash !== 1'b1) begin
            n_fail++; $display("FAIL crash_frozen: got ox=%0d py=%0d want %0d %0d", dut.r_obs_x, dut.r_player_y, m_ox, m_py);
        end
    endtask

    task automatic test_pixels();
        int hq, vq;
        bit ar;
        for (int i = 0; i < 40; i++) begin
            hq = (i % 2) ? $urandom_range(90, 130) : $urandom_range(m_ox > 20 ? m_ox - 20 : 0, 639);
            vq = $urandom_range(0, 479);
            ar = ($urandom_range(0, 7) != 0);
            @(negedge clk); HQ = 10'(hq); VQ = 10'(vq); AR = ar;
            @(posedge clk); #1;
            n_checks++;
            if ({red, green, blue} !== model_colour(hq, vq, ar)) begin
                n_fail++; $display("FAIL pixel hq=%0d vq=%0d ar=%b: got %h want %h", hq, vq, ar, {red, green, blue}, model_colour(hq, vq, ar));
            end
        end
    endtask

    task automatic test_restart();
        do_frame(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (crash !== 1'b0 || score !== 8'd0 || dut.r_obs_x !== 10'd640 ||
            dut.r_player_y !== 10'd232 || dut.r_gap_y !== 10'(m_gy)) begin
            n_fail++; $display("FAIL restart: got cr=%b sc=%0d ox=%0d py=%0d gy=%0d want 0 0 640 232 %0d",
                               crash, score, dut.r_obs_x, dut.r_player_y, dut.r_gap_y, m_gy);
        end
        for (int i = 0; i < 8; i++) do_frame(1'b0, 1'b0, 1'b1);
        test_pixels();
    endtask

    task automatic test_async_reset();
        @(negedge clk); HQ = 10'd300; VQ = 10'd5; AR = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({red, green, blue} !== model_colour(300, 5, 1'b1)) begin
            n_fail++; $display("FAIL pre_reset_pixel: got %h want %h", {red, green, blue}, model_colour(300, 5, 1'b1));
        end
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({red, green, blue} !== 12'h000 || crash !== 1'b0 || score !== 8'd0 || dut.r_obs_x !== 10'd640) begin
            n_fail++; $display("FAIL async_reset: got rgb=%h cr=%b sc=%0d ox=%0d want 0 0 0 640", {red, green, blue}, crash, score, dut.r_obs_x);
        end
        @(negedge clk); rst_n = 1'b1;
        n_checks++;
        if (dut.r_state !== ST_IDLE) begin
            n_fail++; $display("FAIL reset_idle: got state=%0d want IDLE", dut.r_state);
        end
        repeat (3) do_frame(1'b0, 1'b1, 1'b0);
        n_checks++;
        if (dut.r_state !== ST_IDLE || dut.r_obs_x !== 10'd640 || dut.r_player_y !== 10'd232) begin
            n_fail++; $display("FAIL reset_waits: got state=%0d ox=%0d py=%0d want IDLE 640 232", dut.r_state, dut.r_obs_x, dut.r_player_y);
        end
        test_pixels();
        // LFSR alignment after reset: first start loads gap from the reseeded sequence.
        do_frame(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (dut.r_gap_y !== 10'(m_gy)) begin
            n_fail++; $display("FAIL reset_lfsr_gap: got %0d want %0d", dut.r_gap_y, m_gy);
        end
    endtask

    initial begin
        test_reset();
        test_movement();
        test_clamp();
        test_wrap();
        test_collision();
        test_restart();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
